eth_rx_fcs: RTL and testbench

- Sits directly downstream of the GMII receive front end (preamble/SFD stripper), in the on-chip 125 MHz domain.
- Consumes the stripped byte stream and its end-of-frame strobe.
- Removes the trailing 4-byte FCS, checks CRC-32 and frame length, and forwards payload bytes (destination MAC through end of data) with a start marker.
- Emits a one-cycle done pulse carrying frame status for the MAC/UDP parser that follows.

---
 rtl/eth_rx_fcs.sv | 145 ++++++++++++++
 tb/tb_eth_rx_fcs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_fcs.sv
// Receive-side FCS stripper/checker: delays the byte stream by four bytes so the
// trailing CRC is never forwarded, and reports CRC/length status with a done pulse.
module eth_rx_fcs #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 12
) (
  input  logic             c,
  input  logic             rst,
  input  logic [7:0]       rxd,
  input  logic             rxdv,
  input  logic             rxe,
  output logic [7:0]       d,
  output logic             dv,
  output logic             sof,
  output logic             done,
  output logic             good,
  output logic             bad_fcs,
  output logic             runt,
  output logic             giant,
  output logic [LEN_W-1:0] len
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             close;
  logic [31:0]      crc_p0;
  logic [LEN_W-1:0] cnt_p0;
  logic [7:0]       dly_p0 [4];
  logic [31:0]      crc_base;
  logic [LEN_W-1:0] cnt_base;

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] r;
    r = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [LEN_W-1:0] cnt_sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] len_floor(input logic [LEN_W-1:0] v);
    return (v >= LEN_W'(4)) ? v - LEN_W'(4) : '0;
  endfunction

  always_ff @(posedge c) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    close     = 1'b0;
    case (state)
      IDLE: begin
        accept = rxdv;
        if (rxe)       state_nxt = DONE;
        else if (rxdv) state_nxt = RECV;
      end
      RECV: begin
        accept = rxdv;
        if (rxe) state_nxt = DONE;
      end
      DONE: begin
        // rxe is ignored here; a byte arriving now opens the next frame
        close     = 1'b1;
        accept    = rxdv;
        state_nxt = rxdv ? RECV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Closing a frame restarts the accumulators in the same cycle it may accept a new byte
  assign crc_base = close ? CRC_INIT : crc_p0;
  assign cnt_base = close ? '0 : cnt_p0;

  // Stage p0: CRC, byte count and the 4-byte delay line
  always_ff @(posedge c) begin
    if (rst) begin
      crc_p0 <= CRC_INIT;
      cnt_p0 <= '0;
    end else if (accept) begin
      crc_p0 <= crc_upd(crc_base, rxd);
      cnt_p0 <= cnt_sat_inc(cnt_base);
    end else if (close) begin
      crc_p0 <= CRC_INIT;
      cnt_p0 <= '0;
    end
  end

  always_ff @(posedge c) begin
    if (accept) begin
      dly_p0[0] <= rxd;
      dly_p0[1] <= dly_p0[0];
      dly_p0[2] <= dly_p0[1];
      dly_p0[3] <= dly_p0[2];
    end
  end

  // Stage p1: payload output and frame status
  always_ff @(posedge c) begin
    if (rst) begin
      d       <= '0;
      dv      <= 1'b0;
      sof     <= 1'b0;
      done    <= 1'b0;
      good    <= 1'b0;
      bad_fcs <= 1'b0;
      runt    <= 1'b0;
      giant   <= 1'b0;
      len     <= '0;
    end else begin
      dv   <= 1'b0;
      sof  <= 1'b0;
      done <= close;
      // A full delay line means the oldest byte cannot be part of the FCS
      if (accept && cnt_base >= LEN_W'(4)) begin
        d   <= dly_p0[3];
        dv  <= 1'b1;
        sof <= (cnt_base == LEN_W'(4));
      end
      if (close) begin
        bad_fcs <= (crc_p0 != CRC_RESIDUE) || (cnt_p0 < LEN_W'(4));
        runt    <= cnt_p0 < LEN_W'(MIN_LEN);
        giant   <= cnt_p0 > LEN_W'(MAX_LEN);
        good    <= (crc_p0 == CRC_RESIDUE) && (cnt_p0 >= LEN_W'(4)) &&
                   !(cnt_p0 < LEN_W'(MIN_LEN)) && !(cnt_p0 > LEN_W'(MAX_LEN));
        len     <= len_floor(cnt_p0);
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs.sv
// Directed bench for eth_rx_fcs: table of frames plus hand-written sequences for
// zero-length frames, reset mid-frame, rxe with the last byte and back-to-back frames.
module tb_eth_rx_fcs;

  logic        c = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxd = '0;
  logic        rxdv = 1'b0;
  logic        rxe = 1'b0;
  logic [7:0]  d;
  logic        dv, sof, done, good, bad_fcs, runt, giant;
  logic [11:0] len;

  eth_rx_fcs #(.MIN_LEN(64), .MAX_LEN(1518), .LEN_W(12)) dut (
    .c(c), .rst(rst), .rxd(rxd), .rxdv(rxdv), .rxe(rxe),
    .d(d), .dv(dv), .sof(sof), .done(done), .good(good), .bad_fcs(bad_fcs),
    .runt(runt), .giant(giant), .len(len)
  );

  always #4 c = ~c;

  int tests = 0;
  int fails = 0;
  logic [7:0] frame [2048];
  int n_dv = 0, n_sof = 0, byte_err = 0, pay_idx = 0, n_done = 0, n_good = 0;

  typedef struct {
    int n; int flip; int seed;
    bit e_good; bit e_bad; bit e_runt; bit e_giant;
    int e_len; int e_dv;
  } vec_t;

  vec_t vecs [9];

  always @(negedge c) begin
    if (dv) begin
      if (sof) begin
        pay_idx = 0;
        n_sof++;
      end
      if (d !== frame[pay_idx]) byte_err++;
      pay_idx++;
      n_dv++;
    end
    if (done) begin
      n_done++;
      if (good) n_good++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_cnt();
    n_dv = 0; n_sof = 0; byte_err = 0; pay_idx = 0; n_done = 0; n_good = 0;
  endtask

  // Payload bytes, then FCS = ~CRC sent least significant byte first
  task automatic build(input int n, input int flip, input int seed);
    logic [31:0] cr;
    logic [7:0]  b;
    logic        fb;
    int          nd;
    nd = (n >= 4) ? n - 4 : n;
    for (int i = 0; i < nd; i++) frame[i] = 8'((i * 37 + seed * 11 + 5) & 255);
    cr = 32'hFFFFFFFF;
    for (int i = 0; i < nd; i++) begin
      b = frame[i];
      for (int k = 0; k < 8; k++) begin
        fb = cr[0] ^ b[k];
        cr = cr >> 1;
        if (fb) cr = cr ^ 32'hEDB88320;
      end
    end
    cr = ~cr;
    if (n >= 4) begin
      frame[nd]   = cr[7:0];
      frame[nd+1] = cr[15:8];
      frame[nd+2] = cr[23:16];
      frame[nd+3] = cr[31:24];
    end
    if (flip >= 0) frame[flip] = frame[flip] ^ 8'h01;
  endtask

  // rxe_mode: 1 = rxe the cycle after the last byte, 2 = rxe together with the last byte
  task automatic drive(input int n, input int rxe_mode);
    for (int i = 0; i < n; i++) begin
      @(posedge c); #1;
      rxd = frame[i];
      rxdv = 1'b1;
      rxe = (rxe_mode == 2 && i == n - 1);
    end
    @(posedge c); #1;
    rxdv = 1'b0;
    rxd = '0;
    rxe = (rxe_mode == 1);
    @(posedge c); #1;
    rxe = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int k;
    k = 0;
    while (n_done < target && k < 50) begin
      @(negedge c);
      k++;
    end
    if (n_done < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d done pulses expected %0d", nm, n_done, target);
    end
    repeat (3) @(negedge c);
  endtask

  task automatic chk_status(input string nm, input bit eg, input bit eb, input bit er,
                            input bit egi, input int el);
    chk({nm, "_good"}, int'(good), int'(eg));
    chk({nm, "_bad_fcs"}, int'(bad_fcs), int'(eb));
    chk({nm, "_runt"}, int'(runt), int'(er));
    chk({nm, "_giant"}, int'(giant), int'(egi));
    chk({nm, "_len"}, int'(len), el);
  endtask

  initial begin
    vecs[0] = '{n: 64,   flip: -1, seed: 1, e_good: 1, e_bad: 0, e_runt: 0, e_giant: 0, e_len: 60,   e_dv: 60};
    vecs[1] = '{n: 64,   flip: 10, seed: 1, e_good: 0, e_bad: 1, e_runt: 0, e_giant: 0, e_len: 60,   e_dv: 60};
    vecs[2] = '{n: 40,   flip: -1, seed: 2, e_good: 0, e_bad: 0, e_runt: 1, e_giant: 0, e_len: 36,   e_dv: 36};
    vecs[3] = '{n: 1600, flip: -1, seed: 3, e_good: 0, e_bad: 0, e_runt: 0, e_giant: 1, e_len: 1596, e_dv: 1596};
    vecs[4] = '{n: 1518, flip: -1, seed: 4, e_good: 1, e_bad: 0, e_runt: 0, e_giant: 0, e_len: 1514, e_dv: 1514};
    vecs[5] = '{n: 1519, flip: -1, seed: 5, e_good: 0, e_bad: 0, e_runt: 0, e_giant: 1, e_len: 1515, e_dv: 1515};
    vecs[6] = '{n: 63,   flip: -1, seed: 6, e_good: 0, e_bad: 0, e_runt: 1, e_giant: 0, e_len: 59,   e_dv: 59};
    vecs[7] = '{n: 4,    flip: -1, seed: 7, e_good: 0, e_bad: 0, e_runt: 1, e_giant: 0, e_len: 0,    e_dv: 0};
    vecs[8] = '{n: 2,    flip: -1, seed: 8, e_good: 0, e_bad: 1, e_runt: 1, e_giant: 0, e_len: 0,    e_dv: 0};

    repeat (3) @(posedge c);
    @(negedge c);
    chk("reset_dv", int'(dv), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_d", int'(d), 0);
    chk_status("reset", 0, 0, 0, 0, 0);
    @(posedge c); #1;
    rst = 1'b0;
    repeat (2) @(posedge c);

    foreach (vecs[v]) begin
      string nm;
      nm = $sformatf("vec%0d_n%0d", v, vecs[v].n);
      build(vecs[v].n, vecs[v].flip, vecs[v].seed);
      clr_cnt();
      drive(vecs[v].n, 1);
      wait_done(1, nm);
      chk({nm, "_done_cnt"}, n_done, 1);
      chk({nm, "_dv_cnt"}, n_dv, vecs[v].e_dv);
      chk({nm, "_sof_cnt"}, n_sof, (vecs[v].e_dv > 0) ? 1 : 0);
      chk({nm, "_byte_err"}, byte_err, 0);
      chk_status(nm, vecs[v].e_good, vecs[v].e_bad, vecs[v].e_runt, vecs[v].e_giant, vecs[v].e_len);
      repeat (2) @(posedge c);
    end

    // Lone rxe: zero-length frame
    clr_cnt();
    @(posedge c); #1;
    rxe = 1'b1;
    @(posedge c); #1;
    rxe = 1'b0;
    wait_done(1, "zero_len");
    chk("zero_len_done_cnt", n_done, 1);
    chk("zero_len_dv_cnt", n_dv, 0);
    chk_status("zero_len", 0, 1, 1, 0, 0);

    // rxe asserted together with the last byte
    build(64, -1, 9);
    clr_cnt();
    drive(64, 2);
    wait_done(1, "rxe_last");
    chk("rxe_last_done_cnt", n_done, 1);
    chk("rxe_last_dv_cnt", n_dv, 60);
    chk("rxe_last_byte_err", byte_err, 0);
    chk_status("rxe_last", 1, 0, 0, 0, 60);

    // Reset mid-frame: partial frame is dropped, status cleared
    build(64, -1, 10);
    for (int i = 0; i < 30; i++) begin
      @(posedge c); #1;
      rxd = frame[i];
      rxdv = 1'b1;
    end
    @(posedge c); #1;
    rxdv = 1'b0;
    rst = 1'b1;
    @(posedge c); #1;
    rst = 1'b0;
    clr_cnt();
    repeat (8) @(negedge c);
    chk("rst_mid_done_cnt", n_done, 0);
    chk("rst_mid_dv_cnt", n_dv, 0);
    chk("rst_mid_good", int'(good), 0);
    chk("rst_mid_len", int'(len), 0);
    clr_cnt();
    drive(64, 1);
    wait_done(1, "post_rst");
    chk("post_rst_dv_cnt", n_dv, 60);
    chk("post_rst_byte_err", byte_err, 0);
    chk_status("post_rst", 1, 0, 0, 0, 60);

    // Back-to-back: frame 2 starts in the DONE cycle of frame 1
    build(64, -1, 11);
    clr_cnt();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) begin
        @(posedge c); #1;
        rxd = frame[i];
        rxdv = 1'b1;
        rxe = 1'b0;
      end
      @(posedge c); #1;
      rxdv = 1'b0;
      rxd = '0;
      rxe = 1'b1;
    end
    @(posedge c); #1;
    rxe = 1'b0;
    wait_done(2, "b2b");
    chk("b2b_done_cnt", n_done, 2);
    chk("b2b_good_cnt", n_good, 2);
    chk("b2b_sof_cnt", n_sof, 2);
    chk("b2b_dv_cnt", n_dv, 120);
    chk("b2b_byte_err", byte_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
